plic_core: RTL and testbench

PLIC_CORE -- requirements
Module: plic_core

---
 rtl/plic_pkg.sv | 10 +
 rtl/plic_gateway_cell.sv | 48 ++++
 rtl/plic_core.sv | 73 +++++++
 tb/tb_plic_core.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// plic_pkg: gateway state encoding and width helpers shared by the PLIC core
package plic_pkg;
    typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_CLAIMED} gw_state_e;
    function automatic int prio_w(int max_prio);
        return $clog2(max_prio + 1);
    endfunction
    function automatic int src_w(int n_source);
        return $clog2(n_source + 1);
    endfunction
endpackage

// File: rtl/plic_gateway_cell.sv
// plic_gateway_cell: per-source gateway FSM with saturating edge counter
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter int EDGE_CNT_W = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic le_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic ip_o
);
    gw_state_e state_q, state_d;
    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
    logic src_q, rise;
    assign rise = src_i & ~src_q;
    assign ip_o = state_q == GW_PENDING;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GW_IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_i;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = le_i ? cnt_q : '0;
        case (state_q)
            GW_IDLE:    if (le_i ? rise : src_i) state_d = GW_PENDING;
            GW_PENDING: if (claim_i) state_d = GW_CLAIMED;
            GW_CLAIMED: if (complete_i) state_d = (le_i && (cnt_q != '0 || rise)) ? GW_PENDING : GW_IDLE;
            default:    state_d = GW_IDLE;
        endcase
        // an edge coinciding with a complete re-pends without being counted
        if (le_i && state_q != GW_IDLE) begin
            if (state_q == GW_CLAIMED && complete_i)
                cnt_d = (cnt_q != '0) ? cnt_q - EDGE_CNT_W'(1) : cnt_q;
            else if (rise && cnt_q != '1)
                cnt_d = cnt_q + EDGE_CNT_W'(1);
        end
    end
endmodule

// File: rtl/plic_core.sv
// plic_core: interrupt gateways plus per-target priority arbitration and claim/complete routing
module plic_core
    import plic_pkg::*;
#(
    parameter int N_SOURCE   = 64,
    parameter int N_TARGET   = 4,
    parameter int MAX_PRIO   = 7,
    parameter int EDGE_CNT_W = 4,
    localparam int PRIOW = prio_w(MAX_PRIO),
    localparam int SRCW  = src_w(N_SOURCE)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_SOURCE-1:0]          src_i,
    input  logic [N_SOURCE-1:0]          le_i,
    input  logic [N_SOURCE*PRIOW-1:0]    prio_i,
    input  logic [N_TARGET*N_SOURCE-1:0] ie_i,
    input  logic [N_TARGET*PRIOW-1:0]    threshold_i,
    input  logic [N_TARGET-1:0]          claim_i,
    output logic [N_TARGET*SRCW-1:0]     claim_id_o,
    input  logic [N_TARGET-1:0]          complete_i,
    input  logic [N_TARGET*SRCW-1:0]     complete_id_i,
    output logic [N_SOURCE-1:0]          ip_o,
    output logic [N_TARGET-1:0]          eip_o
);
    logic [N_SOURCE-1:0] gw_claim, gw_complete;
    logic [SRCW-1:0] id_d [N_TARGET];
    logic [SRCW-1:0] id_q [N_TARGET];
    for (genvar i = 0; i < N_SOURCE; i++) begin : g_gw
        plic_gateway_cell #(.EDGE_CNT_W(EDGE_CNT_W)) u_gw (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (src_i[i]),
            .le_i       (le_i[i]),
            .claim_i    (gw_claim[i]),
            .complete_i (gw_complete[i]),
            .ip_o       (ip_o[i])
        );
    end
    // strict compare against the running best keeps the lowest ID on ties
    always_comb begin
        logic [PRIOW-1:0] best;
        for (int t = 0; t < N_TARGET; t++) begin
            id_d[t] = '0;
            best    = threshold_i[t*PRIOW +: PRIOW];
            for (int i = 0; i < N_SOURCE; i++) begin
                if (ip_o[i] && ie_i[t*N_SOURCE+i] && prio_i[i*PRIOW +: PRIOW] > best) begin
                    id_d[t] = SRCW'(i + 1);
                    best    = prio_i[i*PRIOW +: PRIOW];
                end
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        for (int t = 0; t < N_TARGET; t++) id_q[t] <= !rst_ni ? '0 : id_d[t];
    end
    always_comb begin
        gw_claim    = '0;
        gw_complete = '0;
        claim_id_o  = '0;
        eip_o       = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            eip_o[t] = id_q[t] != '0;
            claim_id_o[t*SRCW +: SRCW] = id_q[t];
            for (int u = 0; u < t; u++)
                if (claim_i[u] && id_q[u] == id_q[t]) claim_id_o[t*SRCW +: SRCW] = '0;
            for (int i = 0; i < N_SOURCE; i++) begin
                if (claim_i[t] && claim_id_o[t*SRCW +: SRCW] == SRCW'(i + 1)) gw_claim[i] = 1'b1;
                if (complete_i[t] && complete_id_i[t*SRCW +: SRCW] == SRCW'(i + 1)) gw_complete[i] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_plic_core.sv
// tb_plic_core: directed checks of gateways, arbitration, claim/complete and reset
module tb_plic_core;
    localparam int NS = 16, NT = 2, PW = 3, SW = 5;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [NS-1:0] src = '0, le = '0, ip;
    logic [NS*PW-1:0] prio = '0;
    logic [NT*NS-1:0] ie = '0;
    logic [NT*PW-1:0] thr = '0;
    logic [NT-1:0] claim = '0, complete = '0, eip;
    logic [NT*SW-1:0] claim_id, complete_id = '0;
    int checks = 0, failures = 0;
    always #5 clk_i = ~clk_i;
    plic_core #(.N_SOURCE(NS), .N_TARGET(NT), .MAX_PRIO(7), .EDGE_CNT_W(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .src_i(src), .le_i(le), .prio_i(prio), .ie_i(ie),
        .threshold_i(thr), .claim_i(claim), .claim_id_o(claim_id), .complete_i(complete),
        .complete_id_i(complete_id), .ip_o(ip), .eip_o(eip)
    );
    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask
    function automatic int cid(int t);
        return int'(claim_id[t*SW +: SW]);
    endfunction
    task automatic do_claim(int t, int exp_id);
        claim[t] = 1'b1;
        #1;
        check("claim_id", cid(t), exp_id);
        tick();
        claim[t] = 1'b0;
    endtask
    task automatic do_complete(int t, int id);
        complete[t] = 1'b1;
        complete_id[t*SW +: SW] = SW'(id);
        tick();
        complete[t] = 1'b0;
    endtask
    task automatic pulse(int i);
        src[i] = 1'b1;
        tick();
        src[i] = 1'b0;
        tick();
    endtask
    task automatic cfg(int i, int p, bit mode, logic [1:0] en);
        prio[i*PW +: PW] = PW'(p);
        le[i] = mode;
        ie[i] = en[0];
        ie[NS+i] = en[1];
    endtask
    task automatic edge_run(int pulses, int repend, bit bad);
        pulse(1);
        check("edge_eip", eip[0], 1);
        do_claim(0, 2);
        repeat (pulses) pulse(1);
        check("edge_claimed_ip", ip[1], 0);
        if (bad) begin
            do_complete(0, 0);
            do_complete(0, NS + 1);
            check("bad_complete_ip", ip[1], 0);
        end
        for (int k = 0; k <= repend; k++) begin
            do_complete(0, 2);
            check("repend_ip", ip[1], k < repend);
            if (k < repend) begin
                tick();
                do_claim(0, 2);
            end
        end
        tick();
        check("edge_idle_eip", eip[0], 0);
    endtask
    initial begin
        tick();
        tick();
        check("rst_ip", ip, 0);
        check("rst_eip", eip, 0);
        check("rst_claim_id", claim_id, 0);
        rst_ni = 1'b1;
        tick();
        cfg(4, 3, 1'b0, 2'b01);
        src[4] = 1'b1;
        tick();
        check("lvl_ip", ip[4], 1);
        check("lvl_eip_early", eip[0], 0);
        tick();
        check("lvl_eip", eip[0], 1);
        do_claim(0, 5);
        src[4] = 1'b0;
        check("lvl_claimed_ip", ip[4], 0);
        tick();
        check("lvl_claimed_eip", eip[0], 0);
        do_complete(0, 5);
        tick();
        check("lvl_done_ip", ip[4], 0);
        check("lvl_done_eip", eip[0], 0);
        cfg(4, 0, 1'b0, 2'b00);
        cfg(1, 2, 1'b1, 2'b01);
        edge_run(3, 3, 1'b0);
        edge_run(5, 3, 1'b1);
        cfg(1, 0, 1'b1, 2'b00);
        cfg(2, 4, 1'b0, 2'b01);
        cfg(6, 4, 1'b0, 2'b01);
        src[2] = 1'b1;
        src[6] = 1'b1;
        tick();
        tick();
        check("tie_id", cid(0), 3);
        thr[2:0] = 3'd4;
        tick();
        check("thr_eip", eip[0], 0);
        check("thr_id", cid(0), 0);
        thr[2:0] = 3'd0;
        tick();
        do_claim(0, 3);
        tick();
        check("second_id", cid(0), 7);
        do_claim(0, 7);
        src[2] = 1'b0;
        src[6] = 1'b0;
        complete = 2'b11;
        complete_id = {SW'(7), SW'(3)};
        tick();
        complete = 2'b00;
        tick();
        check("tie_done_ip", ip, 0);
        check("tie_done_eip", eip, 0);
        cfg(2, 0, 1'b0, 2'b00);
        cfg(6, 0, 1'b0, 2'b00);
        cfg(8, 5, 1'b0, 2'b11);
        src[8] = 1'b1;
        tick();
        tick();
        check("dual_eip", eip, 3);
        claim = 2'b11;
        #1;
        check("dual_t0_id", cid(0), 9);
        check("dual_t1_id", cid(1), 0);
        tick();
        claim = 2'b00;
        check("dual_claimed_ip", ip[8], 0);
        src[8] = 1'b0;
        do_complete(1, 9);
        tick();
        check("dual_done_ip", ip[8], 0);
        check("dual_done_eip", eip, 0);
        cfg(8, 0, 1'b0, 2'b00);
        cfg(1, 2, 1'b1, 2'b01);
        pulse(1);
        do_claim(0, 2);
        pulse(1);
        pulse(1);
        cfg(4, 3, 1'b0, 2'b01);
        src[4] = 1'b1;
        tick();
        tick();
        check("pre_rst_eip", eip[0], 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ip", ip, 0);
        check("mid_rst_eip", eip, 0);
        check("mid_rst_claim_id", claim_id, 0);
        src[4] = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_ip", ip, 0);
        check("post_rst_eip", eip, 0);
        src[1] = 1'b1;
        tick();
        check("post_rst_edge_ip", ip[1], 1);
        tick();
        check("post_rst_id", cid(0), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
